phase_controller: RTL and testbench
===================================

# phase_controller

Sequencer that drives the shared 3-bit `phase` bus of the multi-cycle processor. Steps every instruction through six phases (fetch, decode, execute, memory, write-back, PC update), stalls in the memory phase on a req/ack handshake with data memory, and handles start, halt, resume and memory-timeout error. The program counter, instruction register and register file qualify their updates on `phase` and the strobes generated here.

## Interface
- `MEM_TIMEOUT`, 15: maximum number of cycles `mem_req` stays high without `mem_ack` before the error halt; legal range 1..255.
- `clock`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- `halt_req`  in  1  halt after the current instruction; sampled only in phase 010.
- `mem_access`  in  1  current instruction needs data memory; sampled in phase 011.
- `mem_ack`  in  1  memory done; honoured only while `mem_req`=1.
- `resume`  in  1  leave HALT; ignored elsewhere.
- `phase`  out  3  current phase code.
- `ir_load`  out  1  high in phase 000.
- `reg_we`  out  1  high in phase 100.
- `pc_en`  out  1  high in phase 101; PC advances or jumps on this edge.
- `mem_req`  out  1  memory request.
- `busy`  out  1  high in phases 000..101.
- `halted`  out  1  high in HALT.
- `err`  out  1  memory timeout occurred; cleared on `resume`.
- `instr_count`  out  16  completed instructions (count of phase-101 cycles).

## Operation
- States and `phase` codes: IDLE=111, FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, PCUP=101, HALT=110.
- IDLE -> FETCH when `start`=1. FETCH->DECODE->EXEC->MEM unconditionally, one cycle each.
- EXEC: `halt_req`=1 sets internal `halt_pending`.
- MEM, `mem_access`=0: one cycle, then WB. With `mem_access`=1: `mem_req`=1 combinationally. The state holds MEM until a cycle with `mem_ack`=1, then moves to WB. `mem_req` drops when the state leaves MEM.
- Timeout: the wait counter clears on MEM entry and increments each MEM cycle with `mem_req`=1 and `mem_ack`=0. In a cycle where the counter equals `MEM_TIMEOUT`-1 and `mem_ack`=0, the next state is HALT and `err` is set. WB and PCUP are skipped and `instr_count` does not increment. `mem_ack` in that cycle takes priority over the timeout.
- WB -> PCUP. PCUP -> HALT if `halt_pending` (the flag clears), otherwise -> FETCH. `instr_count` increments on every PCUP cycle, wrapping from 0xFFFF to 0x0000.
- HALT -> FETCH on `resume`=1; `err` clears on the same edge.
- `ir_load`, `reg_we`, `pc_en` and `busy` are pure decodes of the state register. No decode of `phase` 110 or 111 updates the PC.

## Timing
- Reset (asynchronous): state IDLE, `phase`=111, `halt_pending`=0, wait counter 0, `instr_count`=0; all 1-bit outputs 0. Reset mid-MEM drops `mem_req` immediately.
- An instruction without memory access takes 6 cycles. With `mem_ack` arriving k cycles after `mem_req` rises (k=0 means same cycle), it takes 6+k cycles.
- `start` high in IDLE: `phase`=000 on the next edge.
- `halt_req` sampled in EXEC: the instruction completes, including `pc_en`, and `phase`=110 follows PCUP.
- `mem_req` is high for at most `MEM_TIMEOUT` consecutive cycles.

## Structure
- Shared header `phase_defs.vh`: the eight phase codes (`PH_FETCH`..`PH_IDLE`), used by this block, program_counter, the IR and the register file.
- Sub-module `mem_wait_timer`: 8-bit wait counter with clear, enable and `expire` output (counter == `MEM_TIMEOUT`-1), parameterised by `MEM_TIMEOUT`.

## Test plan
- Reset, then `start` pulse, `mem_access`=0: `phase` is 111, then 000,001,010,011,100,101,000; `pc_en` high exactly 1 cycle in 6; `instr_count`=1 after the first PCUP.
- `mem_access`=1, `mem_ack` 3 cycles after `mem_req` rises: `phase` holds 011 for 4 cycles; `mem_req` high 4 cycles; the instruction takes 9 cycles.
- `MEM_TIMEOUT`=4, no `mem_ack`: `mem_req` high 4 cycles, then `phase`=110, `err`=1, `halted`=1; no `pc_en`; `instr_count` unchanged. Then `resume`: `phase`=000, `err`=0.
- `halt_req`=1 during EXEC: `pc_en` pulses once, then `phase`=110; `start`/`mem_ack` ignored in HALT; `resume` returns to 000.
- Preload 0xFFFF completions, run one more instruction: `instr_count` wraps to 0x0000. Assert `rst`=0 mid-MEM: `phase`=111 and `mem_req`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/phase_controller_pkg.sv
// phase_controller_pkg: phase codes shared by the sequencer, PC, IR and register file
package phase_controller_pkg;
  typedef enum logic [2:0] {
    PH_FETCH  = 3'b000,
    PH_DECODE = 3'b001,
    PH_EXEC   = 3'b010,
    PH_MEM    = 3'b011,
    PH_WB     = 3'b100,
    PH_PCUP   = 3'b101,
    PH_HALT   = 3'b110,
    PH_IDLE   = 3'b111
  } phase_t;
  localparam int WAIT_W = 8;
endpackage

// File: rtl/phase_controller_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the last legal one
module mem_wait_timer
  import phase_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [WAIT_W-1:0] cnt;
  always_ff @(posedge clock or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expire = cnt == WAIT_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/phase_controller.sv
// phase_controller: six-phase instruction sequencer with memory handshake, halt and timeout
module phase_controller
  import phase_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        mem_access,
  input  logic        mem_ack,
  input  logic        resume,
  output logic [2:0]  phase,
  output logic        ir_load,
  output logic        reg_we,
  output logic        pc_en,
  output logic        mem_req,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_count
);
  phase_t state, nxt;
  logic halt_pending, expire, timeout;
  logic [15:0] count_q;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock (clock),
    .rst   (rst),
    .clear (state != PH_MEM),
    .enable(mem_req && !mem_ack),
    .expire(expire)
  );
  always_ff @(posedge clock or negedge rst)
    if (!rst) state <= PH_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    timeout = 1'b0;
    unique case (state)
      PH_IDLE:   nxt = start ? PH_FETCH : PH_IDLE;
      PH_FETCH:  nxt = PH_DECODE;
      PH_DECODE: nxt = PH_EXEC;
      PH_EXEC:   nxt = PH_MEM;
      PH_MEM: begin
        // ack wins over an expiring wait in the same cycle
        timeout = mem_access && !mem_ack && expire;
        nxt = (!mem_access || mem_ack) ? PH_WB : timeout ? PH_HALT : PH_MEM;
      end
      PH_WB:     nxt = PH_PCUP;
      PH_PCUP:   nxt = halt_pending ? PH_HALT : PH_FETCH;
      PH_HALT:   nxt = resume ? PH_FETCH : PH_HALT;
      default:   nxt = PH_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      halt_pending <= 1'b0;
      err <= 1'b0;
      count_q <= '0;
    end else begin
      if (state == PH_EXEC && halt_req) halt_pending <= 1'b1;
      else if (nxt == PH_HALT) halt_pending <= 1'b0;
      if (timeout) err <= 1'b1;
      else if (state == PH_HALT && resume) err <= 1'b0;
      if (state == PH_PCUP) count_q <= count_q + 16'd1;
    end
  assign phase = state;
  assign ir_load = state == PH_FETCH;
  assign reg_we = state == PH_WB;
  assign pc_en = state == PH_PCUP;
  assign mem_req = state == PH_MEM && mem_access;
  assign busy = state != PH_IDLE && state != PH_HALT;
  assign halted = state == PH_HALT;
  assign instr_count = count_q;
endmodule

// File: tb/tb_phase_controller.sv
// tb_phase_controller: directed scenario checks of the phase sequencer
module tb_phase_controller;
  logic clock = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, halt_req = 1'b0, mem_access = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic [2:0] phase;
  logic ir_load, reg_we, pc_en, mem_req, busy, halted, err;
  logic [15:0] instr_count;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  phase_controller #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .rst(rst), .start(start), .halt_req(halt_req),
    .mem_access(mem_access), .mem_ack(mem_ack), .resume(resume),
    .phase(phase), .ir_load(ir_load), .reg_we(reg_we), .pc_en(pc_en),
    .mem_req(mem_req), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  task automatic test_reset;
    rst = 1'b0;
    #12;
    total++;
    if ({phase, ir_load, reg_we, pc_en, mem_req, busy, halted, err, instr_count} !== {3'b111, 7'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset: phase=%b outs=%b cnt=%h want 111/0000000/0000", phase,
               {ir_load, reg_we, pc_en, mem_req, busy, halted, err}, instr_count);
    end
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    total++;
    if (phase !== 3'b111) begin
      bad++;
      $display("FAIL idle_hold: phase=%b want 111", phase);
    end
  endtask

  task automatic test_basic;
    logic [2:0] exp_ph [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000};
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      start = 1'b0;
      total++;
      if (phase !== exp_ph[i] || pc_en !== (i == 5) || ir_load !== (i == 0 || i == 6) ||
          reg_we !== (i == 4) || busy !== 1'b1 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL basic_step%0d: phase=%b pc_en=%b ir=%b we=%b busy=%b req=%b want phase=%b",
                 i, phase, pc_en, ir_load, reg_we, busy, mem_req, exp_ph[i]);
      end
    end
    total++;
    if (instr_count !== 16'd1) begin
      bad++;
      $display("FAIL basic_count: instr_count=%0d want 1", instr_count);
    end
  endtask

  task automatic test_mem_wait;
    int cycles = 0;
    int req_cycles = 0;
    mem_access = 1'b1;
    do begin
      @(negedge clock);
      cycles++;
      if (mem_req) begin
        req_cycles++;
        if (phase !== 3'b011) begin
          total++;
          bad++;
          $display("FAIL memwait_phase: phase=%b while req want 011", phase);
        end
      end
      mem_ack = mem_req && req_cycles == 4;
    end while (phase !== 3'b000 && cycles < 30);
    mem_access = 1'b0;
    mem_ack = 1'b0;
    total++;
    if (cycles !== 9 || req_cycles !== 4) begin
      bad++;
      $display("FAIL memwait_len: cycles=%0d req=%0d want 9/4", cycles, req_cycles);
    end
    total++;
    if (instr_count !== 16'd2) begin
      bad++;
      $display("FAIL memwait_count: instr_count=%0d want 2", instr_count);
    end
  endtask

  task automatic test_timeout;
    int cycles = 0;
    int req_cycles = 0;
    int pc_seen = 0;
    mem_access = 1'b1;
    do begin
      @(negedge clock);
      cycles++;
      if (mem_req) req_cycles++;
      if (pc_en) pc_seen++;
    end while (!halted && cycles < 30);
    mem_access = 1'b0;
    total++;
    if (req_cycles !== 4 || pc_seen !== 0) begin
      bad++;
      $display("FAIL timeout_req: req=%0d pc_en=%0d want 4/0", req_cycles, pc_seen);
    end
    total++;
    if (phase !== 3'b110 || err !== 1'b1 || halted !== 1'b1 || instr_count !== 16'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_halt: phase=%b err=%b halted=%b cnt=%0d busy=%b want 110/1/1/2/0",
               phase, err, halted, instr_count, busy);
    end
    resume = 1'b1;
    @(negedge clock);
    resume = 1'b0;
    total++;
    if (phase !== 3'b000 || err !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL timeout_resume: phase=%b err=%b halted=%b want 000/0/0", phase, err, halted);
    end
  endtask

  task automatic test_halt;
    repeat (2) @(negedge clock);
    total++;
    if (phase !== 3'b010) begin
      bad++;
      $display("FAIL halt_exec: phase=%b want 010", phase);
    end
    halt_req = 1'b1;
    @(negedge clock);
    halt_req = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (phase !== 3'b101 || pc_en !== 1'b1) begin
      bad++;
      $display("FAIL halt_pcup: phase=%b pc_en=%b want 101/1", phase, pc_en);
    end
    @(negedge clock);
    total++;
    if (phase !== 3'b110 || halted !== 1'b1 || pc_en !== 1'b0 || instr_count !== 16'd3 || err !== 1'b0) begin
      bad++;
      $display("FAIL halt_enter: phase=%b halted=%b pc_en=%b cnt=%0d err=%b want 110/1/0/3/0",
               phase, halted, pc_en, instr_count, err);
    end
    start = 1'b1;
    mem_ack = 1'b1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    mem_ack = 1'b0;
    total++;
    if (phase !== 3'b110) begin
      bad++;
      $display("FAIL halt_ignore: phase=%b want 110", phase);
    end
    resume = 1'b1;
    @(negedge clock);
    resume = 1'b0;
    total++;
    if (phase !== 3'b000 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_resume: phase=%b halted=%b want 000/0", phase, halted);
    end
  endtask

  task automatic test_wrap;
    int cycles = 0;
    force dut.count_q = 16'hFFFF;
    @(negedge clock);
    release dut.count_q;
    do begin
      @(negedge clock);
      cycles++;
    end while (phase !== 3'b000 && cycles < 20);
    total++;
    if (instr_count !== 16'h0000 || cycles !== 5) begin
      bad++;
      $display("FAIL wrap: instr_count=%h cycles=%0d want 0000/5", instr_count, cycles);
    end
  endtask

  task automatic test_reset_mid_mem;
    mem_access = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (phase !== 3'b011 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmem_pre: phase=%b req=%b want 011/1", phase, mem_req);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (phase !== 3'b111 || mem_req !== 1'b0 || busy !== 1'b0 || instr_count !== 16'h0) begin
      bad++;
      $display("FAIL rstmem_async: phase=%b req=%b busy=%b cnt=%h want 111/0/0/0000",
               phase, mem_req, busy, instr_count);
    end
    mem_access = 1'b0;
    @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_wait();
    test_timeout();
    test_halt();
    test_wrap();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
